// File: rtl/imm_narrower.sv
// imm_narrower: encodes signed 16-bit words as one SHORT or a HIGH/LOW pair of 12-bit immediates
module imm_narrower #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      in_word,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [11:0]      out_imm,
    output logic [1:0]       out_kind,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] split_count
);
    typedef enum logic [1:0] {IDLE, EMIT_SHORT, EMIT_HIGH, EMIT_LOW} state_t;

    localparam logic [1:0] SHORT = 2'b00;
    localparam logic [1:0] HIGH  = 2'b01;
    localparam logic [1:0] LOW   = 2'b10;

    state_t      state;
    logic [15:0] held;
    logic        fits;

    assign fits = (&in_word[15:11]) | ~(|in_word[15:11]);

    // FSM with all outputs registered; nothing from in_word reaches out_imm combinationally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            held        <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_imm     <= '0;
            out_kind    <= SHORT;
            split_count <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    held      <= in_word;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= fits ? EMIT_SHORT : EMIT_HIGH;
                    out_kind  <= fits ? SHORT : HIGH;
                    out_imm   <= fits ? in_word[11:0] : {8'b0, in_word[15:12]};
                    if (!fits && !(&split_count))
                        split_count <= split_count + 1'b1;
                end
                EMIT_HIGH: if (out_ready) begin
                    state    <= EMIT_LOW;
                    out_kind <= LOW;
                    out_imm  <= held[11:0];
                end
                EMIT_SHORT, EMIT_LOW: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imm_narrower.sv
// tb_imm_narrower: directed table-driven bench for imm_narrower
module tb_imm_narrower;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_word;
    logic        in_valid;
    logic        out_ready;
    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [11:0] out_imm, out_imm2;
    logic [1:0]  out_kind, out_kind2;
    logic [7:0]  split_count;
    logic [1:0]  split_count2;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    imm_narrower #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
        .out_imm(out_imm), .out_kind(out_kind), .out_valid(out_valid), .out_ready(out_ready),
        .split_count(split_count)
    );

    imm_narrower #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready2),
        .out_imm(out_imm2), .out_kind(out_kind2), .out_valid(out_valid2), .out_ready(out_ready),
        .split_count(split_count2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic        split;
        logic [11:0] imm1;
        logic [11:0] imm2;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sat2(input int n);
        return (n > 3) ? 16'd3 : 16'(n);
    endfunction

    // Called on a negedge with the block idle and out_ready high
    task automatic feed(input logic [15:0] w, input logic sp, input logic [11:0] i1, input logic [11:0] i2);
        chk("idle_in_ready", {15'b0, in_ready}, 16'd1);
        in_word  = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_word  = 16'hDEAD;
        chk("beat1_valid", {15'b0, out_valid}, 16'd1);
        chk("beat1_kind", {14'b0, out_kind}, sp ? 16'd1 : 16'd0);
        chk("beat1_imm", {4'b0, out_imm}, {4'b0, i1});
        chk("busy_in_ready", {15'b0, in_ready}, 16'd0);
        if (sp) begin
            exp_cnt++;
            @(negedge clk);
            chk("beat2_valid", {15'b0, out_valid}, 16'd1);
            chk("beat2_kind", {14'b0, out_kind}, 16'd2);
            chk("beat2_imm", {4'b0, out_imm}, {4'b0, i2});
        end
        @(negedge clk);
        chk("done_valid", {15'b0, out_valid}, 16'd0);
        chk("done_in_ready", {15'b0, in_ready}, 16'd1);
        chk("split_count", {8'b0, split_count}, 16'(exp_cnt));
        chk("split_count_sat", {14'b0, split_count2}, sat2(exp_cnt));
    endtask

    initial begin
        vecs[0] = '{16'h07FF, 1'b0, 12'h7FF, 12'h000};
        vecs[1] = '{16'h1234, 1'b1, 12'h001, 12'h234};
        vecs[2] = '{16'hF800, 1'b0, 12'h800, 12'h000};
        vecs[3] = '{16'hF7FF, 1'b1, 12'h00F, 12'h7FF};
        vecs[4] = '{16'h0800, 1'b1, 12'h000, 12'h800};
        vecs[5] = '{16'h0000, 1'b0, 12'h000, 12'h000};
        vecs[6] = '{16'hFFFF, 1'b0, 12'hFFF, 12'h000};
        vecs[7] = '{16'h7FFF, 1'b1, 12'h007, 12'hFFF};

        reset = 1'b1; in_word = 16'h0000; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_valid", {15'b0, out_valid}, 16'd0);
        chk("rst_imm", {4'b0, out_imm}, 16'd0);
        chk("rst_kind", {14'b0, out_kind}, 16'd0);
        chk("rst_split", {8'b0, split_count}, 16'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            feed(vecs[i].word, vecs[i].split, vecs[i].imm1, vecs[i].imm2);

        // Stalled HIGH beat must hold for five cycles
        out_ready = 1'b0;
        in_word = 16'h8001; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_word = 16'h0000;
        exp_cnt++;
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", {15'b0, out_valid}, 16'd1);
            chk("stall_kind", {14'b0, out_kind}, 16'd1);
            chk("stall_imm", {4'b0, out_imm}, 16'h008);
            chk("stall_in_ready", {15'b0, in_ready}, 16'd0);
            if (c < 4) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_low_kind", {14'b0, out_kind}, 16'd2);
        chk("stall_low_imm", {4'b0, out_imm}, 16'h001);
        @(negedge clk);
        chk("stall_done_in_ready", {15'b0, in_ready}, 16'd1);
        chk("stall_split", {8'b0, split_count}, 16'(exp_cnt));

        // Reset during EMIT_LOW drops the pending beat
        in_word = 16'h1234; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_low_kind", {14'b0, out_kind}, 16'd2);
        reset = 1'b1; in_valid = 1'b1; in_word = 16'h4321;
        #1;
        chk("midrst_valid", {15'b0, out_valid}, 16'd0);
        chk("midrst_split", {8'b0, split_count}, 16'd0);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        exp_cnt = 0;
        chk("postrst_in_ready", {15'b0, in_ready}, 16'd1);
        chk("postrst_valid", {15'b0, out_valid}, 16'd0);
        @(negedge clk);
        chk("no_stale_valid", {15'b0, out_valid}, 16'd0);
        chk("no_stale_split", {8'b0, split_count}, 16'd0);

        // Five split words: narrow counter reads 1,2,3,3,3
        for (int i = 0; i < 5; i++)
            feed(16'h1000 + 16'(i), 1'b1, 12'h001, 12'(i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
